// File: rtl/cla_adder16_if.sv
// rtl/cla_adder16_if.sv - operand/result bundle for the 16-bit look-ahead adder
interface cla_adder16_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, cout
  );
endinterface

// File: rtl/cla_adder16.sv
// rtl/cla_adder16.sv - two-level carry look-ahead adder with registered result
module cla_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_adder16_if.slave  bus
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;
  logic [3:0]       pg;
  logic [3:0]       gg;
  logic [4:0]       gc;
  logic [WIDTH-1:0] sum_c;

  assign p = bus.a ^ bus.b;
  assign g = bus.a & bus.b;

  always_comb begin
    pg = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end

    // Group carries are fully expanded from cin so no group waits on another.
    gc[0] = bus.cin;
    gc[1] = gg[0] | (pg[0] & bus.cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & bus.cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & bus.cin);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & bus.cin);

    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum_c = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum  <= sum_c;
        bus.cout <= gc[4];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder16.sv
// tb/tb_cla_adder16.sv - scoreboard bench for the registered look-ahead adder
module tb_cla_adder16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [16:0] sb[$];
  logic [16:0] last_res;
  logic [16:0] exp_res;

  cla_adder16_if bus ();

  cla_adder16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of stimulus, record its expected result, land 1 time unit after capture.
  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic ci);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    bus.cin      = ci;
    if (v) sb.push_back({1'b0, x} + {1'b0, y} + {16'b0, ci});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h4321;
    bus.cin      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b sum=%h cout=%b exp v=0 sum=0000 cout=0",
               bus.out_valid, bus.sum, bus.cout);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    last_res     = '0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== 17'h0) begin
      errors++;
      $display("FAIL reset_idle got v=%b res=%h exp v=0 res=00000",
               bus.out_valid, {bus.cout, bus.sum});
    end
  endtask

  task automatic test_basic;
    drive(1'b1, 16'd3, 16'd2, 1'b0);
    exp_res = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== exp_res || exp_res !== 17'd5) begin
      errors++;
      $display("FAIL basic_3p2 got v=%b res=%h exp v=1 res=%h",
               bus.out_valid, {bus.cout, bus.sum}, 17'd5);
    end
    last_res = exp_res;
  endtask

  task automatic test_back_to_back;
    logic [15:0] va[6];
    logic [15:0] vb[6];
    logic        vc[6];
    logic [16:0] vr[6];
    va = '{16'd7, 16'd15, 16'd20, 16'd50, 16'd100, 16'd255};
    vb = '{16'd5, 16'd10, 16'd25, 16'd30, 16'd200, 16'd255};
    vc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vr = '{17'd13, 17'd25, 17'd46, 17'd80, 17'd301, 17'd510};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      exp_res = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== vr[i] || exp_res !== vr[i]) begin
        errors++;
        $display("FAIL vector_%0d got v=%b res=%0d exp v=1 res=%0d",
                 i, bus.out_valid, {bus.cout, bus.sum}, vr[i]);
      end
      last_res = exp_res;
    end
  endtask

  task automatic test_boundary;
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic        vc[4];
    logic [16:0] vr[4];
    va = '{16'hFFFF, 16'hFFFF, 16'h000F, 16'h0FFF};
    vb = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0001};
    vc = '{1'b1, 1'b1, 1'b0, 1'b0};
    vr = '{17'h10000, 17'h1FFFF, 17'h00010, 17'h01000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      exp_res = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== vr[i]) begin
        errors++;
        $display("FAIL boundary_%0d got v=%b cout=%b sum=%h exp v=1 cout=%b sum=%h",
                 i, bus.out_valid, bus.cout, bus.sum, vr[i][16], vr[i][15:0]);
      end
      last_res = exp_res;
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'hA5A5, 16'h5A5A, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== last_res) begin
        errors++;
        $display("FAIL idle_hold_%0d got v=%b res=%h exp v=0 res=%h",
                 i, bus.out_valid, {bus.cout, bus.sum}, last_res);
      end
    end
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 16'h1111, 16'h2222, 1'b1);
    exp_res = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== exp_res) begin
      errors++;
      $display("FAIL pre_reset got v=%b res=%h exp v=1 res=%h",
               bus.out_valid, {bus.cout, bus.sum}, exp_res);
    end
    bus.in_valid = 1'b1;
    bus.a        = 16'hBEEF;
    bus.b        = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL async_clear got v=%b sum=%h cout=%b exp v=0 sum=0000 cout=0",
               bus.out_valid, bus.sum, bus.cout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== 17'h0) begin
      errors++;
      $display("FAIL discard_in_reset got v=%b res=%h exp v=0 res=00000",
               bus.out_valid, {bus.cout, bus.sum});
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n    = 1'b1;
    last_res = '0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== 17'h0) begin
      errors++;
      $display("FAIL post_reset_idle got v=%b res=%h exp v=0 res=00000",
               bus.out_valid, {bus.cout, bus.sum});
    end
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
    exp_res = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== 17'h00100) begin
      errors++;
      $display("FAIL first_after_reset got v=%b res=%h exp v=1 res=00100",
               bus.out_valid, {bus.cout, bus.sum});
    end
    last_res = exp_res;
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      logic        v;
      logic [15:0] x;
      logic [15:0] y;
      logic        ci;
      v  = ($urandom_range(0, 7) != 0);
      x  = 16'($urandom);
      y  = 16'($urandom);
      ci = 1'($urandom);
      drive(v, x, y, ci);
      checks++;
      if (v) begin
        exp_res = sb.pop_front();
        if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== exp_res) begin
          errors++;
          if (bad < 10)
            $display("FAIL random_%0d a=%h b=%h cin=%b got v=%b res=%h exp v=1 res=%h",
                     i, x, y, ci, bus.out_valid, {bus.cout, bus.sum}, exp_res);
          bad++;
        end
        last_res = exp_res;
      end else if (bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== last_res) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_hold_%0d got v=%b res=%h exp v=0 res=%h",
                   i, bus.out_valid, {bus.cout, bus.sum}, last_res);
        bad++;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover exp 0", sb.size());
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    last_res     = '0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary();
    test_idle();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
